// File: rtl/mux_pkg.sv
// Shared defaults and the select-width helper for the registered N:1 bit selector.
package mux_pkg;

    localparam int   MUX_N_DEF   = 8;
    localparam logic DIS_VAL_DEF = 1'b0;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_core.sv
// Combinational N:1 bit selection; selects that fall past the last input yield DIS_VAL.
import mux_pkg::*;

module mux_sel_core #(
    parameter int   N       = MUX_N_DEF,
    parameter int   SEL_W   = sel_w(MUX_N_DEF),
    parameter logic DIS_VAL = DIS_VAL_DEF
) (
    input  logic [N-1:0]     n,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    // Equality-decoded selection: only the matching bit reaches y, so an
    // unknown value on any other input cannot leak through the index math.
    always_comb begin
        y = DIS_VAL;
        for (int k = 0; k < N; k++) begin
            if (s == SEL_W'(k)) begin
                y = n[k];
            end
        end
    end

endmodule

// File: rtl/mux_8to1_reg.sv
// Registered N:1 bit selector with enable; define MUX_HOLD_EN to make en=0 hold o
// instead of loading DIS_VAL.
import mux_pkg::*;

module mux_8to1_reg #(
    parameter int   N       = MUX_N_DEF,
    parameter int   SEL_W   = sel_w(MUX_N_DEF),
    parameter logic DIS_VAL = DIS_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     n,
    input  logic [SEL_W-1:0] s,
    input  logic             en,
    output logic             o
);

    logic sel_bit;

    generate
        if (SEL_W != sel_w(N)) begin : g_bad_sel_w
            $error("mux_8to1_reg: SEL_W (%0d) must equal clog2(N) (%0d)", SEL_W, sel_w(N));
        end
        if (N < 2 || N > 256) begin : g_bad_n
            $error("mux_8to1_reg: N (%0d) must lie in 2..256", N);
        end
    endgenerate

    mux_sel_core #(
        .N       (N),
        .SEL_W   (SEL_W),
        .DIS_VAL (DIS_VAL)
    ) u_core (
        .n (n),
        .s (s),
        .y (sel_bit)
    );

    // Reset outranks everything; disabled cycles either clear or hold the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o <= DIS_VAL;
        end else if (en) begin
            o <= sel_bit;
        end else begin
`ifdef MUX_HOLD_EN
            o <= o;
`else
            o <= DIS_VAL;
`endif
        end
    end

endmodule

// File: tb/tb_mux_8to1_reg.sv
// Directed self-checking bench for mux_8to1_reg: default 8:1 instance plus a 6:1
// instance for out-of-range selects. Expectations follow MUX_HOLD_EN when defined.
module tb_mux_8to1_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] n;
    logic [2:0] s;
    logic       o;
    logic [5:0] n6;
    logic [2:0] s6;
    logic       o6;

    int checks;
    int errors;

    mux_8to1_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .n     (n),
        .s     (s),
        .en    (en),
        .o     (o)
    );

    mux_8to1_reg #(.N(6), .SEL_W(3)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .n     (n6),
        .s     (s6),
        .en    (en),
        .o     (o6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge, are captured on the next edge,
    // and outputs are sampled 1 time unit after that edge.
    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [7:0] nv, input logic [2:0] sv);
        rst_n = r;
        en    = e;
        n     = nv;
        s     = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] sweep_exp;
        logic       hold_exp;
        logic [7:0] nx;

        checks = 0;
        errors = 0;
        n6 = 6'h3F;
        s6 = 3'd0;
        rst_n = 1'b0;
        en = 1'b1;
        n = 8'hFF;
        s = 3'd0;
        #1;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b1, 8'hFF, 3'd0);
        checkOutput("reset_edge1", o, 1'b0);
        checkOutput("reset_edge1_n6", o6, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 3'd0);
        checkOutput("reset_edge2", o, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 3'd0);
        checkOutput("reset_release", o, 1'b1);

        $display("[TB] select sweep");
        sweep_exp = 8'b0110_1110;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 8'd110, 3'(i));
            checkOutput($sformatf("sweep_s%0d", i), o, sweep_exp[i]);
        end

        $display("[TB] disable");
        applyStimulus(1'b1, 1'b1, 8'hFF, 3'd3);
        checkOutput("pre_disable", o, 1'b1);
`ifdef MUX_HOLD_EN
        hold_exp = 1'b1;
`else
        hold_exp = 1'b0;
`endif
        applyStimulus(1'b1, 1'b0, 8'hFF, 3'd3);
        checkOutput("disable_1", o, hold_exp);
        applyStimulus(1'b1, 1'b0, 8'h00, 3'd5);
        checkOutput("disable_2", o, hold_exp);

        $display("[TB] same-edge change");
        applyStimulus(1'b1, 1'b1, 8'h04, 3'd2);
        checkOutput("same_edge_before", o, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h20, 3'd5);
        checkOutput("same_edge_after", o, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h20, 3'd2);
        checkOutput("stale_select", o, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b1, 8'hFF, 3'd6);
        checkOutput("mid_run", o, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 3'd6);
        checkOutput("mid_reset", o, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 3'd6);
        checkOutput("mid_release", o, 1'b1);

        $display("[TB] unknown on unselected bits");
        nx = 8'bxxxx_x1xx;
        applyStimulus(1'b1, 1'b1, nx, 3'd2);
        checkOutput("x_unselected", o, 1'b1);

        $display("[TB] non-power-of-two instance");
        n6 = 6'h3F;
        s6 = 3'd5;
        applyStimulus(1'b1, 1'b1, 8'h00, 3'd0);
        checkOutput("n6_s5", o6, 1'b1);
        s6 = 3'd6;
        applyStimulus(1'b1, 1'b1, 8'h00, 3'd0);
        checkOutput("n6_s6", o6, 1'b0);
        s6 = 3'd0;
        applyStimulus(1'b1, 1'b1, 8'h00, 3'd0);
        checkOutput("n6_s0", o6, 1'b1);
        s6 = 3'd7;
        applyStimulus(1'b1, 1'b1, 8'h00, 3'd0);
        checkOutput("n6_s7", o6, 1'b0);
        n6 = 6'h10;
        s6 = 3'd4;
        applyStimulus(1'b1, 1'b1, 8'h00, 3'd0);
        checkOutput("n6_s4", o6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
